// File: rtl/bram_dp_pipe.sv
// bram_dp_pipe: single-clock true dual-port RAM with column write enables,
// per-port write mode, pipelined registered reads and sticky error flags.
module bram_dp_pipe #(
  parameter int    COL_WIDTH    = 8,
  parameter int    NB_COL       = 1,
  parameter int    DEPTH        = 307200,
  parameter int    ADDR_W       = 19,
  parameter int    READ_LATENCY = 2,
  parameter string WRITE_MODE_A = "READ_FIRST",
  parameter string WRITE_MODE_B = "READ_FIRST",
  parameter string INIT_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_en,
  input  logic [NB_COL-1:0]           a_we,
  input  logic [ADDR_W-1:0]           a_addr,
  input  logic [NB_COL*COL_WIDTH-1:0] a_din,
  output logic [NB_COL*COL_WIDTH-1:0] a_dout,
  output logic                        a_dout_valid,
  input  logic                        b_en,
  input  logic [NB_COL-1:0]           b_we,
  input  logic [ADDR_W-1:0]           b_addr,
  input  logic [NB_COL*COL_WIDTH-1:0] b_din,
  output logic [NB_COL*COL_WIDTH-1:0] b_dout,
  output logic                        b_dout_valid,
  input  logic                        clear_err,
  output logic                        err_oob,
  output logic                        err_collision
);

  localparam int DW = NB_COL * COL_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam bit [1:0] WF = {WRITE_MODE_B == "WRITE_FIRST",
                             WRITE_MODE_A == "WRITE_FIRST"};
  localparam bit [1:0] NC = {WRITE_MODE_B == "NO_CHANGE",
                             WRITE_MODE_A == "NO_CHANGE"};

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]        en;
  logic [NB_COL-1:0] we   [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DW-1:0]     din  [2];

  assign en      = {b_en, a_en};
  assign we[0]   = a_we;
  assign we[1]   = b_we;
  assign addr[0] = a_addr;
  assign addr[1] = b_addr;
  assign din[0]  = a_din;
  assign din[1]  = b_din;

  logic [1:0]    act, inr, wsel, wr, rd;
  logic [DW-1:0] old   [2];
  logic [DW-1:0] post  [2];
  logic [DW-1:0] rdata [2];
  logic          same;

  assign same = (a_addr == b_addr);

  always_comb begin
    act  = '0;
    inr  = '0;
    wsel = '0;
    wr   = '0;
    rd   = '0;
    for (int p = 0; p < 2; p++) begin
      old[p]  = '0;
      act[p]  = en[p] & ~rst;
      inr[p]  = {1'b0, addr[p]} < DEPTH_L;
      wsel[p] = act[p] & (|we[p]);
      wr[p]   = wsel[p] & inr[p];
      rd[p]   = act[p] & ~(wsel[p] & NC[p]);
      if (inr[p]) old[p] = mem[addr[p]];
    end
  end

  // Post-write word seen at each port: B's columns first, A overlays them.
  always_comb begin
    post[0] = old[0];
    post[1] = old[1];
    for (int c = 0; c < NB_COL; c++) begin
      if (wr[1] && we[1][c]) begin
        post[1][c*COL_WIDTH +: COL_WIDTH] = b_din[c*COL_WIDTH +: COL_WIDTH];
        if (same)
          post[0][c*COL_WIDTH +: COL_WIDTH] = b_din[c*COL_WIDTH +: COL_WIDTH];
      end
      if (wr[0] && we[0][c]) begin
        post[0][c*COL_WIDTH +: COL_WIDTH] = a_din[c*COL_WIDTH +: COL_WIDTH];
        if (same)
          post[1][c*COL_WIDTH +: COL_WIDTH] = a_din[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // A plain reader always sees the pre-write word, even under collision.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = (WF[p] && wsel[p]) ? post[p] : old[p];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NB_COL; c++) begin
      if (wr[1] && we[1][c])
        mem[b_addr][c*COL_WIDTH +: COL_WIDTH] <= b_din[c*COL_WIDTH +: COL_WIDTH];
      if (wr[0] && we[0][c])
        mem[a_addr][c*COL_WIDTH +: COL_WIDTH] <= a_din[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  logic [DW-1:0] pd_q   [2][RL];
  logic [RL-1:0] pv_q   [2];
  logic [DW-1:0] dout_q [2];
  logic [1:0]    vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int p = 0; p < 2; p++) begin
        pv_q[p]   <= '0;
        dout_q[p] <= '0;
        for (int k = 0; k < RL; k++) pd_q[p][k] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pv_q[p][0] <= rd[p];
        pd_q[p][0] <= rdata[p];
        for (int k = 1; k < RL; k++) begin
          pv_q[p][k] <= pv_q[p][k-1];
          pd_q[p][k] <= pd_q[p][k-1];
        end
        vld_q[p] <= pv_q[p][RL-1];
        if (pv_q[p][RL-1]) dout_q[p] <= pd_q[p][RL-1];
      end
    end
  end

  assign a_dout       = dout_q[0];
  assign b_dout       = dout_q[1];
  assign a_dout_valid = vld_q[0];
  assign b_dout_valid = vld_q[1];

  logic oob_ev, col_ev;
  logic oob_q, col_q;

  assign oob_ev = |(act & ~inr);
  assign col_ev = (&act) & inr[0] & same & (|wsel);

  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q <= 1'b0;
      col_q <= 1'b0;
    end else begin
      oob_q <= oob_ev | (oob_q & ~clear_err);
      col_q <= col_ev | (col_q & ~clear_err);
    end
  end

  assign err_oob       = oob_q;
  assign err_collision = col_q;

endmodule

// File: tb/tb_bram_dp_pipe.sv
// tb_bram_dp_pipe: vector table plus read scoreboard for the main RAM,
// hand sequences for reset and a NO_CHANGE / WRITE_FIRST second instance.
module tb_bram_dp_pipe;

  localparam int L   = 2;
  localparam int DEP = 307200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we;
  logic [18:0] a_addr, b_addr;
  logic [31:0] a_din, b_din, a_dout, b_dout;
  logic        a_dout_valid, b_dout_valid;
  logic        clear_err, err_oob, err_collision;

  logic       c_en, d_en, c_we, d_we;
  logic [3:0] c_addr, d_addr;
  logic [7:0] c_din, d_din, c_dout, d_dout;
  logic       c_vld, d_vld, clr2, oob2, col2;

  bram_dp_pipe #(
    .COL_WIDTH(8), .NB_COL(4), .DEPTH(DEP), .ADDR_W(19),
    .READ_LATENCY(L), .WRITE_MODE_A("WRITE_FIRST"),
    .WRITE_MODE_B("READ_FIRST"), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_dout_valid(a_dout_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_dout_valid(b_dout_valid),
    .clear_err(clear_err), .err_oob(err_oob),
    .err_collision(err_collision)
  );

  bram_dp_pipe #(
    .COL_WIDTH(8), .NB_COL(1), .DEPTH(12), .ADDR_W(4),
    .READ_LATENCY(1), .WRITE_MODE_A("NO_CHANGE"),
    .WRITE_MODE_B("WRITE_FIRST"), .INIT_FILE("")
  ) dut2 (
    .clk(clk), .rst(rst),
    .a_en(c_en), .a_we(c_we), .a_addr(c_addr), .a_din(c_din),
    .a_dout(c_dout), .a_dout_valid(c_vld),
    .b_en(d_en), .b_we(d_we), .b_addr(d_addr), .b_din(d_din),
    .b_dout(d_dout), .b_dout_valid(d_vld),
    .clear_err(clr2), .err_oob(oob2), .err_collision(col2)
  );

  typedef struct {
    bit        a_en;
    bit [3:0]  a_we;
    int        a_addr;
    bit [31:0] a_din;
    bit        b_en;
    bit [3:0]  b_we;
    int        b_addr;
    bit [31:0] b_din;
    bit        clr;
    bit        eo;
    bit        ec;
  } vec_t;

  typedef struct {
    int        due;
    bit [31:0] data;
  } exp_t;

  exp_t      qa[$];
  exp_t      qb[$];
  bit [31:0] model [int];
  vec_t      tbl[$];
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [32:0] act,
                     input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t v(input bit ae, input bit [3:0] aw, input int aa,
                             input bit [31:0] ad, input bit be,
                             input bit [3:0] bw, input int ba,
                             input bit [31:0] bd, input bit clr,
                             input bit eo, input bit ec);
    vec_t r;
    r.a_en = ae; r.a_we = aw; r.a_addr = aa; r.a_din = ad;
    r.b_en = be; r.b_we = bw; r.b_addr = ba; r.b_din = bd;
    r.clr = clr; r.eo = eo; r.ec = ec;
    return r;
  endfunction

  function automatic bit [31:0] mrd(input int ad);
    if (ad < DEP && model.exists(ad)) return model[ad];
    return '0;
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] d,
                                      input bit [3:0] we);
    bit [31:0] r = o;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Scoreboard: each due read must show valid with data; no stray pulses.
  always @(negedge clk) begin
    if (qa.size() != 0 && qa[0].due == cyc) begin
      chk("a_read", {a_dout_valid, a_dout}, {1'b1, qa[0].data});
      void'(qa.pop_front());
    end else if (a_dout_valid) begin
      checks++; errors++;
      $display("FAIL a_stray: valid=1 dout=%h at cycle %0d, required valid=0",
               a_dout, cyc);
    end
    if (qb.size() != 0 && qb[0].due == cyc) begin
      chk("b_read", {b_dout_valid, b_dout}, {1'b1, qb[0].data});
      void'(qb.pop_front());
    end else if (b_dout_valid) begin
      checks++; errors++;
      $display("FAIL b_stray: valid=1 dout=%h at cycle %0d, required valid=0",
               b_dout, cyc);
    end
  end

  // Called in the low clock phase; returns after the next negedge.
  task automatic step(input vec_t t, input bit r, input int idx);
    bit        aa, ba, ai, bi;
    bit [31:0] ao, bo;
    int        due;
    rst = r;
    a_en = t.a_en; a_we = t.a_we; a_addr = 19'(t.a_addr); a_din = t.a_din;
    b_en = t.b_en; b_we = t.b_we; b_addr = 19'(t.b_addr); b_din = t.b_din;
    clear_err = t.clr;
    due = cyc + 1 + L;
    if (r) begin
      while (qa.size() != 0 && qa[$].due > cyc) void'(qa.pop_back());
      while (qb.size() != 0 && qb[$].due > cyc) void'(qb.pop_back());
    end else begin
      aa = t.a_en; ba = t.b_en;
      ai = t.a_addr < DEP; bi = t.b_addr < DEP;
      ao = mrd(t.a_addr); bo = mrd(t.b_addr);
      if (ba && bi && t.b_we != 0)
        model[t.b_addr] = merge(mrd(t.b_addr), t.b_din, t.b_we);
      if (aa && ai && t.a_we != 0)
        model[t.a_addr] = merge(mrd(t.a_addr), t.a_din, t.a_we);
      if (aa) qa.push_back('{due, (t.a_we == 0) ? ao : mrd(t.a_addr)});
      if (ba) qb.push_back('{due, bo});
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("oob[%0d]", idx), {32'd0, err_oob}, {32'd0, t.eo});
    chk($sformatf("col[%0d]", idx), {32'd0, err_collision}, {32'd0, t.ec});
  endtask

  task automatic drv2(input bit ae, input bit aw, input int aa,
                      input bit [7:0] ad, input bit be, input bit bw,
                      input int ba, input bit [7:0] bd);
    c_en = ae; c_we = aw; c_addr = 4'(aa); c_din = ad;
    d_en = be; d_we = bw; d_addr = 4'(ba); d_din = bd;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t idle;

  initial begin
    rst = 1'b1; clear_err = 1'b0;
    a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
    c_en = 0; c_we = 0; c_addr = 0; c_din = 0;
    d_en = 0; d_we = 0; d_addr = 0; d_din = 0; clr2 = 0;
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a", {a_dout_valid, a_dout}, 33'd0);
    chk("rst_b", {b_dout_valid, b_dout}, 33'd0);
    chk("rst_flags", {31'd0, err_oob, err_collision}, 33'd0);
    chk("rst2", {c_vld, d_vld, oob2, col2, c_dout, d_dout}, 33'd0);
    rst = 1'b0;

    //          aen awe  aaddr   adin          ben bwe  baddr   bdin   clr eo ec
    tbl.push_back(v(1, 4'hF, 5,      32'h3C,       0, 0,    0,      0,     0, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(v(0, 0,    0,      0,            1, 0,    5,      0,     0, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(v(1, 4'hF, 10,     32'h11223344, 0, 0,    0,      0,     0, 0, 0));
    tbl.push_back(v(1, 4'h5, 10,     32'hAABBCCDD, 0, 0,    0,      0,     0, 0, 0));
    tbl.push_back(v(0, 0,    0,      0,            1, 0,    10,     0,     0, 0, 0));
    tbl.push_back(v(1, 4'hF, 7,      32'h01,       0, 0,    0,      0,     0, 0, 0));
    tbl.push_back(v(0, 0,    0,      0,            1, 4'hF, 7,      32'h02, 0, 0, 0));
    tbl.push_back(v(1, 4'hF, 7,      32'h03,       0, 0,    0,      0,     0, 0, 0));
    tbl.push_back(v(1, 0,    7,      0,            1, 0,    7,      0,     0, 0, 0));
    tbl.push_back(v(1, 4'hF, 100,    32'h0,        0, 0,    0,      0,     0, 0, 0));
    tbl.push_back(v(1, 4'h1, 100,    32'hAA,       1, 4'h1, 100,    32'h55, 0, 0, 1));
    tbl.push_back(v(0, 0,    0,      0,            1, 0,    100,    0,     0, 0, 1));
    tbl.push_back(v(1, 4'hF, 100,    32'h33,       0, 0,    0,      0,     1, 0, 0));
    tbl.push_back(v(1, 4'hF, 100,    32'h77,       1, 0,    100,    0,     0, 0, 1));
    tbl.push_back(v(1, 0,    100,    0,            1, 4'h2, 100,    32'h9900, 1, 0, 1));
    tbl.push_back(v(0, 0,    0,      0,            0, 0,    0,      0,     1, 0, 0));
    tbl.push_back(v(1, 4'hF, 307200, 32'hDEAD,     0, 0,    0,      0,     0, 1, 0));
    tbl.push_back(v(1, 0,    307201, 0,            0, 0,    0,      0,     0, 1, 0));
    tbl.push_back(v(0, 0,    0,      0,            0, 0,    0,      0,     1, 0, 0));
    tbl.push_back(v(0, 0,    0,      0,            1, 0,    524287, 0,     1, 1, 0));
    tbl.push_back(v(1, 4'hF, 307199, 32'hCAFEF00D, 0, 0,    0,      0,     1, 0, 0));
    tbl.push_back(v(0, 0,    0,      0,            1, 0,    307199, 0,     0, 0, 0));
    tbl.push_back(v(0, 0,    0,      0,            1, 0,    100,    0,     0, 0, 0));
    tbl.push_back(v(1, 0,    400000, 0,            0, 0,    0,      0,     0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, i);

    // Reset mid-read: both reads and the write under reset must vanish.
    step(v(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 100);
    step(v(1, 0, 5, 0, 1, 4'hF, 5, 32'hFFFFFFFF, 0, 0, 0), 1'b1, 101);
    chk("rst_mid_a", {1'b0, a_dout}, 33'd0);
    chk("rst_mid_b", {1'b0, b_dout}, 33'd0);
    for (int i = 0; i < 4; i++) step(idle, 1'b0, 102 + i);
    step(v(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 110);
    for (int i = 0; i < L + 2; i++) step(idle, 1'b0, 111 + i);
    chk("drain_a", {1'b0, 32'(qa.size())}, 33'd0);
    chk("drain_b", {1'b0, 32'(qb.size())}, 33'd0);

    // Second instance: A is NO_CHANGE, B is WRITE_FIRST, latency 1.
    drv2(0, 0, 0, 0, 1, 1, 7, 8'h01);
    drv2(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wf_b", {d_vld, 24'd0, d_dout}, {1'b1, 24'd0, 8'h01});
    drv2(1, 0, 7, 0, 0, 0, 0, 0);
    drv2(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nc_rd", {c_vld, 24'd0, c_dout}, {1'b1, 24'd0, 8'h01});
    drv2(1, 1, 7, 8'h02, 0, 0, 0, 0);
    drv2(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nc_wr", {c_vld, 24'd0, c_dout}, {1'b0, 24'd0, 8'h01});
    drv2(0, 0, 0, 0, 1, 0, 7, 0);
    drv2(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nc_mem", {d_vld, 24'd0, d_dout}, {1'b1, 24'd0, 8'h02});
    drv2(1, 0, 7, 0, 1, 1, 7, 8'h05);
    drv2(0, 0, 0, 0, 0, 0, 0, 0);
    chk("col2_a", {c_vld, 24'd0, c_dout}, {1'b1, 24'd0, 8'h02});
    chk("col2_b", {d_vld, 24'd0, d_dout}, {1'b1, 24'd0, 8'h05});
    chk("col2_f", {31'd0, oob2, col2}, {31'd0, 1'b0, 1'b1});
    drv2(1, 0, 12, 0, 0, 0, 0, 0);
    drv2(0, 0, 0, 0, 0, 0, 0, 0);
    chk("oob2_rd", {c_vld, 24'd0, c_dout}, {1'b1, 32'd0});
    chk("oob2_f", {32'd0, oob2}, 33'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
